mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WORDS, default 8, words per cache block; supported values are 2, 4 and 8, and fill_word is always 3 bits wide.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 ic_miss  in  1  I-cache fill request; level signal, held until ic_done.
REQ-005 ic_miss_addr  in  16  I-cache miss byte address.
REQ-006 dc_miss  in  1  D-cache fill request; level signal, held until dc_done.
REQ-007 dc_miss_addr  in  16  D-cache miss byte address.
REQ-008 dc_wr_req  in  1  D-cache write-through request; level signal, held until dc_wr_ack.
REQ-009 dc_wr_addr / dc_wr_data  in  16 / 16  write-through address and data.
REQ-010 mem_data_valid  in  1  memory read data valid; one pulse per issued read, in issue order.
REQ-011 mem_en / mem_wr  out  1 / 1  memory access strobe / write select.
REQ-012 mem_addr / mem_wdata  out  16 / 16  memory address / write data.
REQ-013 ic_fsm_busy / dc_fsm_busy  out  1 / 1  fill in progress for that cache.
REQ-014 ic_fill_we / dc_fill_we  out  1 / 1  write the returned word into that cache's data array.
REQ-015 fill_word  out  3  index of the returned word within the block.
REQ-016 ic_done / dc_done  out  1 / 1  single-cycle pulse on the last returned word.
REQ-017 dc_wr_ack  out  1  single-cycle pulse in the cycle the write is issued.

Function
REQ-018 The FSM has four states: IDLE, WRITE, FILL_D and FILL_I; exactly one transaction is in flight at a time.
REQ-019 In IDLE, priority is fixed at dc_wr_req > dc_miss > ic_miss; the winner is sampled in IDLE and the FSM enters its state on the next edge.
REQ-020 Starvation guard: if ic_miss was pending when a FILL_D completed, the next IDLE arbitration grants FILL_I ahead of a new dc_miss, but not ahead of dc_wr_req.
REQ-021 WRITE lasts one cycle with mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data and dc_wr_ack=1; the FSM then returns to IDLE.
REQ-022 On entry to FILL_x, the base address is latched as {addr[15:4], 4'h0} from the granted miss address.
REQ-023 In FILL_x, mem_en=1 and mem_wr=0 for exactly WORDS consecutive cycles, starting in the first FILL cycle; mem_addr = base + 2*k for k = 0..WORDS-1.
REQ-024 Reads remain pipelined during a fill; an issue counter and a return counter run independently.
REQ-025 On each mem_data_valid in FILL_x: x_fill_we=1 and fill_word equals the return count (0..WORDS-1).
REQ-026 The return count increments on each mem_data_valid and wraps to 0 after WORDS-1.
REQ-027 x_done=1 in the same cycle as the WORDS-th mem_data_valid; the FSM returns to IDLE on the next edge.
REQ-028 x_fsm_busy=1 for every cycle the FSM is in FILL_x, including the done cycle.
REQ-029 Every transaction is followed by at least one IDLE cycle, so a requester may drop its request on the edge that samples done or ack.
REQ-030 No preemption: a dc_wr_req or dc_miss arriving during FILL_I waits until FILL_I completes.
REQ-031 Requests whose address changes while the transaction is in flight are ignored; the latched base address is used.
REQ-032 mem_data_valid is ignored in IDLE and WRITE: no fill_we, no counter change.
REQ-033 Additional mem_data_valid pulses beyond the WORDS-th pulse of the current fill are not counted.
REQ-034 When idle, mem_en=0, mem_wr=0, all pulses=0, and mem_addr/mem_wdata hold 16'h0000.

Reset
REQ-035 With rst_n=0 at a clock edge: state=IDLE, counters=0, base=16'h0000, and all outputs 0 in the following cycle.
REQ-036 Reset mid-fill aborts the fill with no done pulse; read data still returning from memory is discarded per REQ-032.
REQ-037 Reset has priority over every request present in the same cycle.

Verification
REQ-038 Lone ic_miss, addr 16'hEEE4 -> 8 reads EEE0, EEE2 .. EEEE on consecutive cycles; with 4-cycle memory latency, ic_fill_we on words 0..7, ic_done on the 8th valid, ic_fsm_busy drops the next cycle.
REQ-039 dc_wr_req (addr 16'h1234, data 16'hBEEF), dc_miss (16'h0040) and ic_miss (16'h0100) raised in the same cycle -> WRITE (one cycle, ack), then IDLE, then FILL_D reads 0040..004E, then FILL_I reads 0100..010E.
REQ-040 dc_wr_req raised in the 3rd cycle of FILL_I -> no mem_wr until ic_done; write issued after one IDLE cycle.
REQ-041 Starvation: dc_miss held continuously while ic_miss is pending -> after the first D fill, an I fill is granted before the second D fill.
REQ-042 rst_n=0 after the 3rd valid of a D fill, with 5 late valids arriving afterwards -> no dc_fill_we, no dc_done, all outputs 0; a new ic_miss after reset fills normally from word 0.
REQ-043 Stray mem_data_valid pulses while IDLE -> no fill_we and no counter change; the next fill's fill_word sequence starts at 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: memory-side bus between the fill/write-through arbiter and
// the memory controller.
//   mem_en         access strobe, one cycle per read or write
//   mem_wr         1 = write, 0 = read
//   mem_addr       byte address (16'h0000 when no access is issued)
//   mem_wdata      write data (16'h0000 unless a write is issued)
//   mem_data_valid read data return, one pulse per issued read, in order
// Modports: master = arbiter side, slave = memory side.
interface mem_arbiter_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_data_valid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_data_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache fills, D-cache fills
// and D-cache write-through. One transaction in flight at a time; fill reads
// are pipelined (issue and return counted independently).
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   ic_miss / ic_miss_addr      I-cache fill request (level) and byte address
//   dc_miss / dc_miss_addr      D-cache fill request (level) and byte address
//   dc_wr_req / addr / data     D-cache write-through request (level)
//   mem                         memory bus (mem_arbiter_if.master)
//   ic_fsm_busy / dc_fsm_busy   fill in progress for that cache
//   ic_fill_we / dc_fill_we     returned word write enable for that cache
//   fill_word                   index of the returned word in the block
//   ic_done / dc_done           pulse with the last returned word
//   dc_wr_ack                   pulse in the cycle the write is issued
//
// state  | meaning
// IDLE   | no transaction, arbitrate wr_req > (starved I fill) > dc_miss > ic_miss
// WRITE  | single-cycle write-through on the bus, ack pulsed
// FILL_D | D-cache block fill, WORDS reads issued, WORDS returns awaited
// FILL_I | I-cache block fill, WORDS reads issued, WORDS returns awaited
module mem_arbiter #(
  parameter int WORDS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ic_miss,
  input  logic [15:0]         ic_miss_addr,
  input  logic                dc_miss,
  input  logic [15:0]         dc_miss_addr,
  input  logic                dc_wr_req,
  input  logic [15:0]         dc_wr_addr,
  input  logic [15:0]         dc_wr_data,
  mem_arbiter_if.master       mem,
  output logic                ic_fsm_busy,
  output logic                dc_fsm_busy,
  output logic                ic_fill_we,
  output logic                dc_fill_we,
  output logic [2:0]          fill_word,
  output logic                ic_done,
  output logic                dc_done,
  output logic                dc_wr_ack
);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_D, FILL_I} state_t;

  localparam logic [2:0] LAST   = 3'(WORDS - 1);
  localparam logic [3:0] NWORDS = 4'(WORDS);

  state_t      state;
  logic [15:0] base;
  logic [3:0]  issue_cnt;
  logic [2:0]  ret_cnt;
  logic        ic_prio;

  logic in_fill;
  logic ret_valid;
  logic last_ret;
  logic unused_low;

  // Block alignment drops the low address nibble.
  assign unused_low = ^{ic_miss_addr[3:0], dc_miss_addr[3:0]};

  assign in_fill   = (state == FILL_D) || (state == FILL_I);
  assign ret_valid = in_fill && mem.mem_data_valid;
  assign last_ret  = ret_valid && (ret_cnt == LAST);

  assign ic_fsm_busy = (state == FILL_I);
  assign dc_fsm_busy = (state == FILL_D);
  assign ic_fill_we  = ret_valid && (state == FILL_I);
  assign dc_fill_we  = ret_valid && (state == FILL_D);
  assign ic_done     = last_ret && (state == FILL_I);
  assign dc_done     = last_ret && (state == FILL_D);
  assign fill_word   = ret_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      base          <= 16'h0000;
      issue_cnt     <= 4'd0;
      ret_cnt       <= 3'd0;
      ic_prio       <= 1'b0;
      mem.mem_en    <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_addr  <= 16'h0000;
      mem.mem_wdata <= 16'h0000;
      dc_wr_ack     <= 1'b0;
    end else begin
      dc_wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!ic_miss) ic_prio <= 1'b0;
          if (dc_wr_req) begin
            state         <= WRITE;
            mem.mem_en    <= 1'b1;
            mem.mem_wr    <= 1'b1;
            mem.mem_addr  <= dc_wr_addr;
            mem.mem_wdata <= dc_wr_data;
            dc_wr_ack     <= 1'b1;
          end else if (dc_miss && !(ic_prio && ic_miss)) begin
            state        <= FILL_D;
            base         <= {dc_miss_addr[15:4], 4'h0};
            mem.mem_en   <= 1'b1;
            mem.mem_addr <= {dc_miss_addr[15:4], 4'h0};
            issue_cnt    <= 4'd1;
          end else if (ic_miss) begin
            state        <= FILL_I;
            ic_prio      <= 1'b0;
            base         <= {ic_miss_addr[15:4], 4'h0};
            mem.mem_en   <= 1'b1;
            mem.mem_addr <= {ic_miss_addr[15:4], 4'h0};
            issue_cnt    <= 4'd1;
          end
        end
        WRITE: begin
          state         <= IDLE;
          mem.mem_en    <= 1'b0;
          mem.mem_wr    <= 1'b0;
          mem.mem_addr  <= 16'h0000;
          mem.mem_wdata <= 16'h0000;
        end
        FILL_D, FILL_I: begin
          // issue_cnt counts reads already placed on the bus.
          if (issue_cnt < NWORDS) begin
            mem.mem_addr <= base + {11'b0, issue_cnt, 1'b0};
            issue_cnt    <= issue_cnt + 4'd1;
          end else begin
            mem.mem_en   <= 1'b0;
            mem.mem_addr <= 16'h0000;
          end
          if (ret_valid) ret_cnt <= last_ret ? 3'd0 : ret_cnt + 3'd1;
          if (last_ret) begin
            state        <= IDLE;
            mem.mem_en   <= 1'b0;
            mem.mem_addr <= 16'h0000;
            issue_cnt    <= 4'd0;
            // An I miss that waited out a D fill goes next.
            if (state == FILL_D && ic_miss) ic_prio <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
